// File: rtl/regfile_ctrl.sv
// Command-driven access controller for the 16x8 register file: READ/WRITE/CLEAR
// commands in on valid/ready, regfile port drive out, read responses on valid/ready.
module regfile_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr_w,
  output logic [DW-1:0] rf_data_in,
  output logic [AW-1:0] rf_addr_r,
  input  logic [DW-1:0] rf_data_out
);

  localparam int unsigned NREGS = 2 ** AW;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_RSP, S_CLR} state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_cnt, w_cnt_n;
  logic          r_rf_we, w_rf_we_n;
  logic [AW-1:0] r_rf_addr_w, w_rf_addr_w_n;
  logic [DW-1:0] r_rf_data_in, w_rf_data_in_n;
  logic [AW-1:0] r_rf_addr_r, w_rf_addr_r_n;
  logic          r_rsp_valid, w_rsp_valid_n;
  logic [AW-1:0] r_rsp_addr, w_rsp_addr_n;
  logic [DW-1:0] r_rsp_data, w_rsp_data_n;
  logic          w_accept;

  assign cmd_ready  = (r_state == S_IDLE) & ~rst;
  assign w_accept   = cmd_valid & cmd_ready;
  assign busy       = (r_state != S_IDLE);
  assign rf_we      = r_rf_we;
  assign rf_addr_w  = r_rf_addr_w;
  assign rf_data_in = r_rf_data_in;
  assign rf_addr_r  = r_rf_addr_r;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_addr   = r_rsp_addr;
  assign rsp_data   = r_rsp_data;

  // Next-state and next registered-output logic; write enable is a one-cycle pulse by default
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_rf_we_n      = 1'b0;
    w_rf_addr_w_n  = r_rf_addr_w;
    w_rf_data_in_n = r_rf_data_in;
    w_rf_addr_r_n  = r_rf_addr_r;
    w_rsp_valid_n  = r_rsp_valid;
    w_rsp_addr_n   = r_rsp_addr;
    w_rsp_data_n   = r_rsp_data;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_WRITE: begin
              w_rf_we_n      = 1'b1;
              w_rf_addr_w_n  = cmd_addr;
              w_rf_data_in_n = cmd_data;
            end
            OP_READ: begin
              w_rf_addr_r_n = cmd_addr;
              w_state_n     = S_RD;
            end
            OP_CLEAR: begin
              w_state_n      = S_CLR;
              w_cnt_n        = '0;
              w_rf_we_n      = 1'b1;
              w_rf_addr_w_n  = '0;
              w_rf_data_in_n = '0;
            end
            default: ;
          endcase
        end
      end
      S_RD: begin
        w_rsp_data_n  = rf_data_out;
        w_rsp_addr_n  = r_rf_addr_r;
        w_rsp_valid_n = 1'b1;
        w_state_n     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_n = 1'b0;
          w_state_n     = S_IDLE;
        end
      end
      S_CLR: begin
        // rf_addr_w tracks the counter so each sweep cycle shows the entry being zeroed
        w_cnt_n = r_cnt + AW'(1);
        if (r_cnt == AW'(NREGS - 1)) begin
          w_state_n = S_IDLE;
        end else begin
          w_rf_we_n      = 1'b1;
          w_rf_addr_w_n  = r_cnt + AW'(1);
          w_rf_data_in_n = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rf_we      <= 1'b0;
      r_rf_addr_w  <= '0;
      r_rf_data_in <= '0;
      r_rf_addr_r  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_addr   <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_rf_we      <= w_rf_we_n;
      r_rf_addr_w  <= w_rf_addr_w_n;
      r_rf_data_in <= w_rf_data_in_n;
      r_rf_addr_r  <= w_rf_addr_r_n;
      r_rsp_valid  <= w_rsp_valid_n;
      r_rsp_addr   <= w_rsp_addr_n;
      r_rsp_data   <= w_rsp_data_n;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural 16x8 regfile, shadow model of its contents,
// and a response scoreboard fed at command accept and drained on rsp handshakes.
module tb_regfile_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          rf_we;
  logic [AW-1:0] rf_addr_w;
  logic [DW-1:0] rf_data_in;
  logic [AW-1:0] rf_addr_r;
  logic [DW-1:0] rf_data_out;

  logic [DW-1:0] mem    [16];
  logic [DW-1:0] shadow [16];
  rsp_t          sb [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            we_cnt   = 0;

  regfile_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .busy(busy),
    .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data_in(rf_data_in),
    .rf_addr_r(rf_addr_r), .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Regfile: no reset, combinational read
  assign rf_data_out = mem[rf_addr_r];
  always @(posedge clk) if (rf_we) mem[rf_addr_w] <= rf_data_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response monitor: handshake completes at the next posedge
  always @(negedge clk) begin
    if (rf_we) we_cnt++;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 32'(rsp_addr), 32'hFFFF_FFFF);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check_eq("rsp_addr", 32'(rsp_addr), 32'(e.addr));
        check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) begin
      check_eq("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (op == OP_READ) sb.push_back('{addr: a, data: shadow[a]});
    if (op == OP_WRITE) shadow[a] = d;
    tick();
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin tick(); n++; end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      check_eq("fill_ready", 32'(cmd_ready), 32'd1);
      send_cmd(OP_WRITE, AW'(i), DW'(10 + i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 16; i++) begin mem[i] = 8'hEE; shadow[i] = 8'hEE; end
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rf_addr_w", 32'(rf_addr_w), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);

    // 1: write then read with latency check
    send_cmd(OP_WRITE, 4'd3, 8'hA5);
    check_eq("t1_we", 32'(rf_we), 32'd1);
    check_eq("t1_addr_w", 32'(rf_addr_w), 32'd3);
    check_eq("t1_data_in", 32'(rf_data_in), 32'hA5);
    send_cmd(OP_READ, 4'd3, 8'h00);
    check_eq("t1_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_drain();

    // 2: back-to-back writes and readback
    we_cnt = 0;
    fill16();
    @(negedge clk); #1;
    check_eq("t2_we_pulses", 32'(we_cnt), 32'd16);
    for (int i = 0; i < 16; i++) send_cmd(OP_READ, AW'(i), 8'h00);
    wait_drain();

    // 3: response backpressure
    rsp_ready = 1'b0;
    send_cmd(OP_READ, 4'd9, 8'h00);
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    for (int c = 0; c < 5; c++) begin
      check_eq("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("t3_hold_data", 32'(rsp_data), 32'd19);
      check_eq("t3_hold_addr", 32'(rsp_addr), 32'd9);
      check_eq("t3_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("t3_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("t3_ready_after", 32'(cmd_ready), 32'd1);
    check_eq("t3_busy_after", 32'(busy), 32'd0);
    check_eq("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: full clear sweep
    send_cmd(OP_CLEAR, 4'd0, 8'h00);
    k = 0;
    while (busy && k < 40) begin
      check_eq("t4_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("t4_we", 32'(rf_we), 32'd1);
      check_eq("t4_addr_w", 32'(rf_addr_w), 32'(k));
      check_eq("t4_data_in", 32'(rf_data_in), 32'd0);
      k++;
      tick();
    end
    check_eq("t4_busy_cycles", 32'(k), 32'd16);
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 16; i++) send_cmd(OP_READ, AW'(i), 8'h00);
    wait_drain();

    // 5: reset during sweep cycle 5
    fill16();
    send_cmd(OP_CLEAR, 4'd0, 8'h00);
    k = 0;
    while (busy && k < 5) begin k++; tick(); end
    check_eq("t5_addr_at_abort", 32'(rf_addr_w), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_we_after_rst", 32'(rf_we), 32'd0);
    check_eq("t5_busy_after_rst", 32'(busy), 32'd0);
    tick();
    check_eq("t5_we_later", 32'(rf_we), 32'd0);
    for (int i = 0; i < 5; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 16; i++) if (i != 5) send_cmd(OP_READ, AW'(i), 8'h00);
    wait_drain();

    // 6: write-then-read hazard, then NOP
    send_cmd(OP_WRITE, 4'd7, 8'h3C);
    send_cmd(OP_READ, 4'd7, 8'h00);
    wait_drain();
    send_cmd(OP_NOP, 4'd2, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      check_eq("t6_nop_we", 32'(rf_we), 32'd0);
      check_eq("t6_nop_rsp", 32'(rsp_valid), 32'd0);
      check_eq("t6_nop_ready", 32'(cmd_ready), 32'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
